sa_os_engine: RTL and testbench

- Parametrised output-stationary systolic matrix-multiply engine, ROWS x COLS (not square-only).
- Integrates input skew, a K-beat load sequencer, flush and a backpressured row-by-row result drain with handshakes; no external skew/set_reg pattern generation needed.
- Computes C = A(ROWS x K) * B(K x COLS) with runtime K and signed/unsigned mode.
- Sits between the IFM/weight buffers (input stream) and the OFM writer (output stream).

---
 rtl/sa_pkg.sv | 37 +++
 rtl/sa_os_engine_if.sv | 33 +++
 rtl/sa_os_pe.sv | 43 ++++
 rtl/sa_os_engine.sv | 208 ++++++++++++++++++++
 tb/tb_sa_os_engine.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/sa_pkg.sv
// Shared types and helpers for the output-stationary systolic engine.
// Holds the FSM encoding, the flush length and the extend-and-multiply used by every PE.
package sa_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    FLUSH = 2'd2,
    DRAIN = 2'd3
  } state_t;

  localparam int MAX_OPERAND_W = 32;

  function automatic int flush_cyc(input int rows, input int cols);
    return rows + cols - 1;
  endfunction

  // Operands are at most MAX_OPERAND_W bits.
  // The 64-bit product is exact, so resizing it to the accumulator width gives the wrapped sum term.
  function automatic logic signed [63:0] mul_ext(input logic [31:0] a, input logic [31:0] b,
                                                 input int unsigned dw, input logic sgn);
    logic [63:0] ea;
    logic [63:0] eb;
    logic [31:0] ta;
    logic [31:0] tb;
    ea = {32'd0, a};
    eb = {32'd0, b};
    ta = a >> (dw - 32'd1);
    tb = b >> (dw - 32'd1);
    if (sgn && ta[0]) ea = ea | (64'hFFFF_FFFF_FFFF_FFFF << dw);
    else              ea = ea;
    if (sgn && tb[0]) eb = eb | (64'hFFFF_FFFF_FFFF_FFFF << dw);
    else              eb = eb;
    return $signed(ea * eb);
  endfunction

endpackage

// File: rtl/sa_os_engine_if.sv
// Operand-stream / result-stream bundle of the systolic engine.
// The engine uses the slave view and the feeding side uses the master view.
interface sa_os_engine_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ROWS       = 4,
  parameter int COLS       = 4,
  parameter int ACC_WIDTH  = 24,
  parameter int KW         = 16
);
  logic                      start;
  logic [KW-1:0]             k_len;
  logic                      signed_mode;
  logic                      in_valid;
  logic                      in_ready;
  logic [ROWS*DATA_WIDTH-1:0] left_in;
  logic [COLS*DATA_WIDTH-1:0] top_in;
  logic                      out_valid;
  logic                      out_ready;
  logic [COLS*ACC_WIDTH-1:0] out_data;
  logic                      out_last;
  logic                      busy;
  logic                      done;

  modport master (
    output start, k_len, signed_mode, in_valid, left_in, top_in, out_ready,
    input  in_ready, out_valid, out_data, out_last, busy, done
  );

  modport slave (
    input  start, k_len, signed_mode, in_valid, left_in, top_in, out_ready,
    output in_ready, out_valid, out_data, out_last, busy, done
  );
endinterface

// File: rtl/sa_os_pe.sv
// One output-stationary processing element.
// It forwards operands right/down and accumulates in place; it can also take its accumulator from the PE above during drain.
module sa_os_pe
  import sa_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 24
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] left_op,
  input  logic [DATA_WIDTH-1:0] top_op,
  input  logic                  signed_mode,
  input  logic                  mac_en,
  input  logic                  clear,
  input  logic                  shift_en,
  input  logic [ACC_WIDTH-1:0]  acc_in,
  output logic [DATA_WIDTH-1:0] right_out,
  output logic [DATA_WIDTH-1:0] bottom_out,
  output logic [ACC_WIDTH-1:0]  acc_out
);

  logic signed [63:0] prod;

  assign prod = mul_ext(32'(left_op), 32'(top_op), DATA_WIDTH, signed_mode);

  // Operand pipeline and accumulator; clear wins over shift, shift wins over MAC.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      right_out  <= '0;
      bottom_out <= '0;
      acc_out    <= '0;
    end else begin
      right_out  <= left_op;
      bottom_out <= top_op;
      if (clear)         acc_out <= '0;
      else if (shift_en) acc_out <= acc_in;
      else if (mac_en)   acc_out <= acc_out + ACC_WIDTH'(prod);
      else               acc_out <= acc_out;
    end
  end

endmodule

// File: rtl/sa_os_engine.sv
// ROWS x COLS output-stationary matrix-multiply engine.
// It contains the input skew, the K-beat load sequencer, the flush and a backpressured row-by-row drain.
module sa_os_engine
  import sa_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ROWS       = 4,
  parameter int COLS       = 4,
  parameter int ACC_WIDTH  = 24,
  parameter int KW         = 16
) (
  input  logic          clk,
  input  logic          rst,
  sa_os_engine_if.slave bus
);

  localparam logic [15:0] FLUSH_LAST = 16'(flush_cyc(ROWS, COLS) - 1);
  localparam logic [15:0] ROW_LAST   = 16'(ROWS - 1);
  localparam logic        ONE_ROW    = 1'(ROWS == 1);

  state_t          state, state_nxt;
  logic [KW-1:0]   k_r, beat_cnt;
  logic            sgn_r;
  logic [15:0]     flush_cnt, row_cnt;
  logic            in_ready_r, out_valid_r, out_last_r, busy_r, done_r;
  logic            in_ready_nxt, out_valid_nxt, out_last_nxt, busy_nxt, done_nxt;
  logic            beat, clear, hs, mac_en;

  logic [DATA_WIDTH-1:0] left_z [ROWS];
  logic [DATA_WIDTH-1:0] top_z  [COLS];
  logic [DATA_WIDTH-1:0] left_sk [ROWS];
  logic [DATA_WIDTH-1:0] top_sk  [COLS];
  logic [DATA_WIDTH-1:0] a_r [ROWS][COLS];
  logic [DATA_WIDTH-1:0] b_d [ROWS][COLS];
  logic [ACC_WIDTH-1:0]  acc_q [ROWS][COLS];

  assign beat   = bus.in_valid && in_ready_r;
  assign clear  = (state == IDLE) && bus.start;
  assign hs     = out_valid_r && bus.out_ready;
  assign mac_en = (state == LOAD) || (state == FLUSH);

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.out_last  = out_last_r;
  assign bus.busy      = busy_r;
  assign bus.done      = done_r;

  // Lanes carry zero whenever no beat is accepted, so bubbles and flush add nothing.
  always_comb begin
    for (int i = 0; i < ROWS; i++) left_z[i] = beat ? bus.left_in[i*DATA_WIDTH +: DATA_WIDTH] : '0;
    for (int j = 0; j < COLS; j++) top_z[j]  = beat ? bus.top_in[j*DATA_WIDTH +: DATA_WIDTH] : '0;
  end

  // Result row presented is always the bottom accumulator row.
  always_comb begin
    bus.out_data = '0;
    for (int j = 0; j < COLS; j++) bus.out_data[j*ACC_WIDTH +: ACC_WIDTH] = acc_q[ROWS-1][j];
  end

  for (genvar i = 0; i < ROWS; i++) begin : g_lsk
    if (i == 0) begin : g_direct
      assign left_sk[0] = left_z[0];
    end else begin : g_dly
      logic [DATA_WIDTH-1:0] sk [i];
      // Left lane i delayed by i cycles.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int d = 0; d < i; d++) sk[d] <= '0;
        end else begin
          sk[0] <= left_z[i];
          for (int d = 1; d < i; d++) sk[d] <= sk[d-1];
        end
      end
      assign left_sk[i] = sk[i-1];
    end
  end

  for (genvar j = 0; j < COLS; j++) begin : g_tsk
    if (j == 0) begin : g_direct
      assign top_sk[0] = top_z[0];
    end else begin : g_dly
      logic [DATA_WIDTH-1:0] sk [j];
      // Top lane j delayed by j cycles.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int d = 0; d < j; d++) sk[d] <= '0;
        end else begin
          sk[0] <= top_z[j];
          for (int d = 1; d < j; d++) sk[d] <= sk[d-1];
        end
      end
      assign top_sk[j] = sk[j-1];
    end
  end

  for (genvar i = 0; i < ROWS; i++) begin : g_row
    for (genvar j = 0; j < COLS; j++) begin : g_col
      logic [DATA_WIDTH-1:0] l_op, t_op;
      logic [ACC_WIDTH-1:0]  a_in;
      if (j == 0) begin : g_l0
        assign l_op = left_sk[i];
      end else begin : g_ln
        assign l_op = a_r[i][j-1];
      end
      if (i == 0) begin : g_t0
        assign t_op = top_sk[j];
        assign a_in = '0;
      end else begin : g_tn
        assign t_op = b_d[i-1][j];
        assign a_in = acc_q[i-1][j];
      end
      sa_os_pe #(.DATA_WIDTH(DATA_WIDTH), .ACC_WIDTH(ACC_WIDTH)) u_pe (
        .clk(clk), .rst(rst), .left_op(l_op), .top_op(t_op), .signed_mode(sgn_r),
        .mac_en(mac_en), .clear(clear), .shift_en(hs), .acc_in(a_in),
        .right_out(a_r[i][j]), .bottom_out(b_d[i][j]), .acc_out(acc_q[i][j])
      );
    end
  end

  // Next state and next values of the registered handshake outputs.
  always_comb begin
    state_nxt     = state;
    in_ready_nxt  = 1'b0;
    out_valid_nxt = 1'b0;
    out_last_nxt  = 1'b0;
    done_nxt      = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          if (bus.k_len == '0) begin
            state_nxt     = DRAIN;
            out_valid_nxt = 1'b1;
            out_last_nxt  = ONE_ROW;
          end else begin
            state_nxt    = LOAD;
            in_ready_nxt = 1'b1;
          end
        end else begin
          state_nxt = IDLE;
        end
      end
      LOAD: begin
        if (beat && (beat_cnt == k_r - KW'(1))) state_nxt = FLUSH;
        else                                    in_ready_nxt = 1'b1;
      end
      FLUSH: begin
        if (flush_cnt == FLUSH_LAST) begin
          state_nxt     = DRAIN;
          out_valid_nxt = 1'b1;
          out_last_nxt  = ONE_ROW;
        end else begin
          state_nxt = FLUSH;
        end
      end
      DRAIN: begin
        if (hs) begin
          if (row_cnt == ROW_LAST) begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
          end else begin
            out_valid_nxt = 1'b1;
            out_last_nxt  = (row_cnt + 16'd1 == ROW_LAST);
          end
        end else begin
          out_valid_nxt = 1'b1;
          out_last_nxt  = out_last_r;
        end
      end
      default: state_nxt = IDLE;
    endcase
    busy_nxt = (state_nxt != IDLE);
  end

  // State, handshake outputs, job parameters and counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
      out_last_r  <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      k_r         <= '0;
      sgn_r       <= 1'b0;
      beat_cnt    <= '0;
      flush_cnt   <= 16'd0;
      row_cnt     <= 16'd0;
    end else begin
      state       <= state_nxt;
      in_ready_r  <= in_ready_nxt;
      out_valid_r <= out_valid_nxt;
      out_last_r  <= out_last_nxt;
      busy_r      <= busy_nxt;
      done_r      <= done_nxt;
      if (clear) begin
        k_r      <= bus.k_len;
        sgn_r    <= bus.signed_mode;
        beat_cnt <= '0;
      end else if (beat) begin
        beat_cnt <= beat_cnt + KW'(1);
      end
      flush_cnt <= (state == FLUSH) ? flush_cnt + 16'd1 : 16'd0;
      if (state != DRAIN) row_cnt <= 16'd0;
      else if (hs)        row_cnt <= row_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_sa_os_engine.sv
// Directed bench for sa_os_engine: a default 4x4 instance, a 2x3 instance and a 16-bit-accumulator instance.
module tb_sa_os_engine;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sa_os_engine_if #(.DATA_WIDTH(8), .ROWS(4), .COLS(4), .ACC_WIDTH(24), .KW(16)) b4 ();
  sa_os_engine_if #(.DATA_WIDTH(8), .ROWS(2), .COLS(3), .ACC_WIDTH(24), .KW(16)) b23 ();
  sa_os_engine_if #(.DATA_WIDTH(8), .ROWS(4), .COLS(4), .ACC_WIDTH(16), .KW(16)) b16 ();

  sa_os_engine #(.DATA_WIDTH(8), .ROWS(4), .COLS(4), .ACC_WIDTH(24), .KW(16))
    u4 (.clk(clk), .rst(rst), .bus(b4.slave));
  sa_os_engine #(.DATA_WIDTH(8), .ROWS(2), .COLS(3), .ACC_WIDTH(24), .KW(16))
    u23 (.clk(clk), .rst(rst), .bus(b23.slave));
  sa_os_engine #(.DATA_WIDTH(8), .ROWS(4), .COLS(4), .ACC_WIDTH(16), .KW(16))
    u16 (.clk(clk), .rst(rst), .bus(b16.slave));

  int total = 0;
  int bad   = 0;
  int w;
  int n;

  logic [7:0]  a_m [4][4];
  logic [7:0]  b_m [4][4];
  logic [95:0] exp_rows [4];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0b want %0b", tag, obs, exp);
    end
  endtask

  task automatic fill_identity();
    for (int i = 0; i < 4; i++)
      for (int k = 0; k < 4; k++) begin
        a_m[i][k] = (i == k) ? 8'd1 : 8'd0;
        b_m[i][k] = 8'(4 * i + k + 1);
      end
    for (int r = 0; r < 4; r++)
      for (int j = 0; j < 4; j++) exp_rows[r][j*24 +: 24] = 24'(4 * (3 - r) + j + 1);
  endtask

  task automatic fill_const(input logic [7:0] av, input logic [7:0] bv, input logic [23:0] ev);
    for (int i = 0; i < 4; i++)
      for (int k = 0; k < 4; k++) begin
        a_m[i][k] = av;
        b_m[i][k] = bv;
      end
    for (int r = 0; r < 4; r++) exp_rows[r] = {4{ev}};
  endtask

  task automatic start4(input int k, input logic sgn);
    b4.start       = 1'b1;
    b4.k_len       = 16'(k);
    b4.signed_mode = sgn;
    @(negedge clk);
    b4.start = 1'b0;
  endtask

  task automatic feed4(input int k, input bit bubbles);
    for (int kk = 0; kk < k; kk++) begin
      if (bubbles && (kk == 1 || $urandom_range(0, 1) == 1)) begin
        b4.in_valid = 1'b0;
        b4.left_in  = {4{8'hAA}};
        b4.top_in   = {4{8'h55}};
        @(negedge clk);
      end
      chk1("in_ready", b4.in_ready, 1'b1);
      b4.in_valid = 1'b1;
      for (int i = 0; i < 4; i++) b4.left_in[i*8 +: 8] = a_m[i][kk];
      for (int j = 0; j < 4; j++) b4.top_in[j*8 +: 8]  = b_m[kk][j];
      @(negedge clk);
    end
    b4.in_valid = 1'b0;
  endtask

  task automatic drain4(input bit stall, output int wait_cyc);
    logic [95:0] held;
    int cnt;
    wait_cyc = 0;
    b4.out_ready = !stall;
    for (int r = 0; r < 4; r++) begin
      cnt = 0;
      while (b4.out_valid !== 1'b1 && cnt < 60) begin
        @(negedge clk);
        cnt++;
      end
      if (r == 0) wait_cyc = cnt;
      chk1("out_valid", b4.out_valid, 1'b1);
      if (stall) begin
        held = b4.out_data;
        for (int s = 0; s < 5; s++) begin
          @(negedge clk);
          chk("hold_data", 128'(b4.out_data), 128'(held));
          chk1("hold_valid", b4.out_valid, 1'b1);
          chk1("hold_last", b4.out_last, (r == 3));
        end
      end
      chk($sformatf("row%0d", r), 128'(b4.out_data), 128'(exp_rows[r]));
      chk1("out_last", b4.out_last, (r == 3));
      b4.out_ready = 1'b1;
      @(negedge clk);
      b4.out_ready = !stall;
    end
    chk1("done", b4.done, 1'b1);
    chk1("valid_after", b4.out_valid, 1'b0);
    chk1("busy_after", b4.busy, 1'b0);
    @(negedge clk);
    chk1("done_once", b4.done, 1'b0);
    b4.out_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    b4.start = 1'b0;  b4.k_len = 16'd0;  b4.signed_mode = 1'b0;  b4.in_valid = 1'b0;
    b4.left_in = '0;  b4.top_in = '0;    b4.out_ready = 1'b0;
    b23.start = 1'b0; b23.k_len = 16'd0; b23.signed_mode = 1'b0; b23.in_valid = 1'b0;
    b23.left_in = '0; b23.top_in = '0;   b23.out_ready = 1'b0;
    b16.start = 1'b0; b16.k_len = 16'd0; b16.signed_mode = 1'b0; b16.in_valid = 1'b0;
    b16.left_in = '0; b16.top_in = '0;   b16.out_ready = 1'b0;
    repeat (2) @(negedge clk);

    // reset state
    chk1("rst_busy", b4.busy, 1'b0);
    chk1("rst_in_ready", b4.in_ready, 1'b0);
    chk1("rst_out_valid", b4.out_valid, 1'b0);
    chk1("rst_out_last", b4.out_last, 1'b0);
    chk1("rst_done", b4.done, 1'b0);
    chk("rst_out_data", 128'(b4.out_data), 128'd0);
    rst = 1'b0;
    @(negedge clk);

    // identity, including first-result latency (7 flush cycles after the last beat)
    fill_identity();
    start4(4, 1'b0);
    chk1("busy_load", b4.busy, 1'b1);
    feed4(4, 1'b0);
    chk1("in_ready_off", b4.in_ready, 1'b0);
    drain4(1'b0, w);
    chk("latency", 128'(w), 128'd7);

    // signed and unsigned 0xFF * 0x02
    fill_const(8'hFF, 8'h02, 24'hFFFFFE);
    start4(1, 1'b1);
    feed4(1, 1'b0);
    drain4(1'b0, w);
    fill_const(8'hFF, 8'h02, 24'd510);
    start4(1, 1'b0);
    feed4(1, 1'b0);
    drain4(1'b0, w);

    // bubbles and backpressure; start during the job must be ignored
    fill_identity();
    start4(4, 1'b0);
    b4.start = 1'b1;
    feed4(4, 1'b1);
    b4.start = 1'b0;
    drain4(1'b1, w);

    // zero K
    fill_const(8'h00, 8'h00, 24'd0);
    start4(0, 1'b0);
    drain4(1'b0, w);
    chk("zero_k_latency", 128'(w), 128'd0);

    // non-square 2x3, A all 1, B all 3, K=2
    b23.out_ready = 1'b1;
    b23.start = 1'b1; b23.k_len = 16'd2;
    @(negedge clk);
    b23.start = 1'b0;
    b23.in_valid = 1'b1; b23.left_in = {2{8'd1}}; b23.top_in = {3{8'd3}};
    repeat (2) @(negedge clk);
    b23.in_valid = 1'b0;
    for (int r = 0; r < 2; r++) begin
      n = 0;
      while (b23.out_valid !== 1'b1 && n < 60) begin @(negedge clk); n++; end
      chk1("ns_valid", b23.out_valid, 1'b1);
      chk("ns_row", 128'(b23.out_data), 128'({3{24'd6}}));
      chk1("ns_last", b23.out_last, (r == 1));
      @(negedge clk);
    end
    chk1("ns_done", b23.done, 1'b1);
    chk1("ns_valid_after", b23.out_valid, 1'b0);

    // 16-bit accumulator wrap: 2 * 255 * 255 mod 65536
    b16.out_ready = 1'b1;
    b16.start = 1'b1; b16.k_len = 16'd2;
    @(negedge clk);
    b16.start = 1'b0;
    b16.in_valid = 1'b1; b16.left_in = {4{8'hFF}}; b16.top_in = {4{8'hFF}};
    repeat (2) @(negedge clk);
    b16.in_valid = 1'b0;
    for (int r = 0; r < 4; r++) begin
      n = 0;
      while (b16.out_valid !== 1'b1 && n < 60) begin @(negedge clk); n++; end
      chk1("wrap_valid", b16.out_valid, 1'b1);
      chk("wrap_row", 128'(b16.out_data), 128'({4{16'd64514}}));
      chk1("wrap_last", b16.out_last, (r == 3));
      @(negedge clk);
    end
    chk1("wrap_done", b16.done, 1'b1);

    // reset in the middle of LOAD, then a clean identity job
    fill_identity();
    start4(4, 1'b0);
    feed4(2, 1'b0);
    rst = 1'b1;
    #1;
    chk1("mid_rst_busy", b4.busy, 1'b0);
    chk1("mid_rst_in_ready", b4.in_ready, 1'b0);
    chk1("mid_rst_out_valid", b4.out_valid, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk1("post_rst_idle", b4.busy, 1'b0);
    start4(4, 1'b0);
    feed4(4, 1'b0);
    drain4(1'b0, w);
    chk("post_rst_latency", 128'(w), 128'd7);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
